aes_round_ctrl: RTL

Parametrised AES round-sequencing controller that replaces the fixed 128-bit, free-running cipher FSM. It drives the state-register write enables, the state-mux select and the round-key index for the shared round datapath. It supports AES-128/192/256 and both encryption and decryption, with configurable SubBytes/MixColumns pipeline latencies and a start/busy/done handshake. It sits between the host-side I/O wrapper and the round datapath and key-schedule RAM.

---
 rtl/aes_round_ctrl_if.sv | 27 ++
 rtl/aes_round_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl_if.sv
// Host/datapath-facing signal bundle of the AES round sequencer.
// The sequencer uses the slave view. The host-side wrapper or bench uses the master view.
interface aes_round_ctrl_if;
  logic       start;
  logic [1:0] key_len;
  logic       decrypt;
  logic       busy;
  logic       done;
  logic       inv;
  logic       wr_en_in_reg;
  logic       wr_en_state_reg;
  logic       wr_en_out_reg;
  logic [2:0] sel_state;
  logic [3:0] sel_key;

  modport master (
    output start, key_len, decrypt,
    input  busy, done, inv, wr_en_in_reg, wr_en_state_reg, wr_en_out_reg,
           sel_state, sel_key
  );

  modport slave (
    input  start, key_len, decrypt,
    output busy, done, inv, wr_en_in_reg, wr_en_state_reg, wr_en_out_reg,
           sel_state, sel_key
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for a shared AES round datapath: AES-128/192/256, cipher and inverse cipher.
// It drives the state-register write enables, the state-mux select and the round-key index.
module aes_round_ctrl #(
  parameter int SB_CYCLES = 6,
  parameter int MC_CYCLES = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  aes_round_ctrl_if.slave bus
);
  localparam int MAX_CYC = (SB_CYCLES > MC_CYCLES) ? SB_CYCLES : MC_CYCLES;
  localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [PH_W-1:0] SB_LAST = PH_W'(SB_CYCLES - 1);
  localparam logic [PH_W-1:0] MC_LAST = PH_W'(MC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARK, S_SB, S_SR, S_MC, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [3:0]      nr_q, nr_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            inv_q, inv_d;
  logic            final_ark;

  logic       we_in, we_state, we_out, done;
  logic [2:0] sel_state;
  logic [3:0] sel_key;

  function automatic logic [3:0] rounds_of(input logic [1:0] kl);
    case (kl)
      2'b01:   rounds_of = 4'd12;
      2'b10:   rounds_of = 4'd14;
      default: rounds_of = 4'd10;
    endcase
  endfunction

  // The last key addition writes the output register instead of the state.
  assign final_ark = inv_q ? (rnd_q == 4'd0) : (rnd_q == nr_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      nr_q    <= 4'd0;
      ph_q    <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      nr_q    <= nr_d;
      ph_q    <= ph_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    nr_d      = nr_q;
    ph_d      = ph_q;
    inv_d     = inv_q;
    we_in     = 1'b0;
    we_state  = 1'b0;
    we_out    = 1'b0;
    done      = 1'b0;
    sel_state = 3'b000;
    sel_key   = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          nr_d    = rounds_of(bus.key_len);
          inv_d   = bus.decrypt;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        we_in    = 1'b1;
        we_state = 1'b1;
        rnd_d    = inv_q ? nr_q : 4'd0;
        state_d  = S_ARK;
      end
      S_ARK: begin
        sel_state = 3'b100;
        sel_key   = rnd_q;
        if (final_ark) begin
          we_out  = 1'b1;
          state_d = S_DONE;
        end else begin
          we_state = 1'b1;
          if (!inv_q) begin
            rnd_d   = rnd_q + 4'd1;
            state_d = S_SB;
          end else if (rnd_q == nr_q) begin
            // The initial decrypt key addition has no InvMixColumns behind it.
            rnd_d   = rnd_q - 4'd1;
            state_d = S_SR;
          end else begin
            state_d = S_MC;
          end
        end
      end
      S_SB: begin
        sel_state = 3'b001;
        sel_key   = rnd_q;
        if (ph_q == SB_LAST) begin
          we_state = 1'b1;
          ph_d     = '0;
          state_d  = inv_q ? S_ARK : S_SR;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_SR: begin
        sel_state = 3'b010;
        sel_key   = rnd_q;
        we_state  = 1'b1;
        if (inv_q)                state_d = S_SB;
        else if (rnd_q == nr_q)   state_d = S_ARK;
        else                      state_d = S_MC;
      end
      S_MC: begin
        sel_state = 3'b011;
        sel_key   = rnd_q;
        if (ph_q == MC_LAST) begin
          we_state = 1'b1;
          ph_d     = '0;
          if (inv_q) begin
            rnd_d   = rnd_q - 4'd1;
            state_d = S_SR;
          end else begin
            state_d = S_ARK;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        rnd_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done            = done;
  assign bus.inv             = inv_q;
  assign bus.wr_en_in_reg    = we_in;
  assign bus.wr_en_state_reg = we_state;
  assign bus.wr_en_out_reg   = we_out;
  assign bus.sel_state       = sel_state;
  assign bus.sel_key         = sel_key;
endmodule
